// File: rtl/uart_tx_serial.sv
`timescale 1ns/1ps
// uart_tx_serial: transmit half of the CPU serial port.
// Bytes written by the IO stage are buffered in a small circular FIFO and
// sent as 8N1 frames (start, 8 data bits LSB first, stop) on a registered txd.
module uart_tx_serial #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD       = 115200,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    output logic       tx_full,
    output logic       tx_idle,
    output logic       overflow,
    output logic       txd
);
    // One bit period is DIV clocks; very low ratios are clamped so the
    // down-counter always has at least two states.
    localparam int DIV_RAW = CLK_FREQ / BAUD;
    localparam int DIV     = (DIV_RAW < 2) ? 2 : DIV_RAW;
    localparam int BW      = $clog2(DIV);
    localparam int PW      = $clog2(FIFO_DEPTH);
    localparam int CW      = PW + 1;

    localparam logic [BW-1:0] BAUD_LOAD = BW'(DIV - 1);
    localparam logic [CW-1:0] FULL_CNT  = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [BW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          txd_q, txd_d;
    logic          tx_full_q, tx_full_d;
    logic          tx_idle_q, tx_idle_d;
    logic          overflow_q, overflow_d;
    logic [7:0]    mem_q [FIFO_DEPTH];

    logic          wr_acc;
    logic          pop;
    logic          fifo_nonempty;

    // Fullness is the registered flag, i.e. judged before any pop this cycle.
    assign wr_acc        = wr_en && !tx_full_q;
    assign fifo_nonempty = (count_q != '0);

    // Next-state logic of the serialiser: frame sequencing, bit timing, pops.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        txd_d   = 1'b1;
        unique case (state_q)
            IDLE: begin
                txd_d = 1'b1;
                if (fifo_nonempty) begin
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = BAUD_LOAD;
                    state_d = START;
                end
            end
            START: begin
                txd_d = 1'b0;
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            DATA: begin
                txd_d = shift_q[0];
                if (baud_q == '0) begin
                    baud_d  = BAUD_LOAD;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            STOP: begin
                txd_d = 1'b1;
                if (baud_q == '0) begin
                    // Chain straight into the next start bit when more data waits.
                    if (fifo_nonempty) begin
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        baud_d  = BAUD_LOAD;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q - BW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping and the registered status flags derived from next state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d    = count_q + CW'(wr_acc) - CW'(pop);
        overflow_d = overflow_q | (wr_en & tx_full_q);
        tx_full_d  = (count_d == FULL_CNT);
        tx_idle_d  = (count_d == '0) && (state_d == IDLE);
    end

    // Control state with asynchronous reset; reset also forces the line high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            txd_q      <= 1'b1;
            tx_full_q  <= 1'b0;
            tx_idle_q  <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            txd_q      <= txd_d;
            tx_full_q  <= tx_full_d;
            tx_idle_q  <= tx_idle_d;
            overflow_q <= overflow_d;
        end
    end

    // Datapath storage: FIFO entries and the shift register need no reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    assign txd      = txd_q;
    assign tx_full  = tx_full_q;
    assign tx_idle  = tx_idle_q;
    assign overflow = overflow_q;

endmodule

// File: tb/tb_uart_tx_serial.sv
`timescale 1ns/100ps
// Bench for uart_tx_serial: randomized and directed writes, a queue-based
// reference of the transmit schedule, and a line monitor that decodes frames.
module tb_uart_tx_serial;
    localparam int DIV   = 16;
    localparam int DEPTH = 4;
    localparam int FRAME = 10 * DIV;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       tx_full;
    logic       tx_idle;
    logic       overflow;
    logic       txd;

    uart_tx_serial #(
        .CLK_FREQ  (16),
        .BAUD      (1),
        .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .tx_full (tx_full),
        .tx_idle (tx_idle),
        .overflow(overflow),
        .txd     (txd)
    );

    initial clk = 1'b1;
    always #1 clk = ~clk;

    // Edges since the last reset release.
    int ecnt;
    always @(posedge clk or posedge rst) begin
        if (rst) ecnt <= 0;
        else     ecnt <= ecnt + 1;
    end

    typedef struct {
        logic [7:0] b;
        int         start;
    } exp_t;

    exp_t expq[$];      // expected frames: byte and edge at which txd first reads low
    int   popq[$];      // edge at which each accepted, not yet sent byte leaves the FIFO
    int   sched_end;    // edge at which the transmitter is free for another byte
    logic ovf_m;

    int   checks   = 0;
    int   failures = 0;
    bit   mon_busy = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    task automatic model_reset();
        expq.delete();
        popq.delete();
        sched_end = 0;
        ovf_m     = 1'b0;
    endtask

    // One clock: check status against the model, then drive the next edge.
    // A byte accepted at edge te leaves the FIFO at the later of te+1 and the
    // end of the previously scheduled frame; its start bit shows one edge later.
    task automatic tick(input logic we, input logic [7:0] d);
        int  t;
        int  p;
        bit  full;
        @(negedge clk);
        t = ecnt;
        while (popq.size() > 0 && popq[0] <= t) void'(popq.pop_front());
        full = (popq.size() == DEPTH);
        chk("tx_full", int'(tx_full), int'(full));
        chk("tx_idle", int'(tx_idle), int'(t >= sched_end));
        chk("overflow", int'(overflow), int'(ovf_m));
        wr_en   = we;
        wr_data = d;
        if (we) begin
            if (full) begin
                ovf_m = 1'b1;
            end else begin
                p = (t + 2 > sched_end) ? t + 2 : sched_end;
                popq.push_back(p);
                sched_end = p + FRAME;
                expq.push_back('{b: d, start: p + 1});
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00);
    endtask

    // Line monitor: on each start bit pops the expected frame, checks when it
    // began, every cycle of its shape, and the byte decoded at mid-bit.
    initial begin : monitor
        int         s;
        int         off;
        int         k;
        int         bad;
        logic       eb;
        logic [7:0] dec;
        exp_t       cur;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_busy = 0;
            end else begin
                if (!mon_busy && txd == 1'b0) begin
                    if (expq.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_frame: start bit seen at edge %0d with no byte outstanding", ecnt);
                        cur = '{b: 8'h00, start: ecnt};
                    end else begin
                        cur = expq.pop_front();
                        chk("frame_start_edge", ecnt, cur.start);
                    end
                    s        = ecnt;
                    bad      = 0;
                    dec      = 8'h00;
                    mon_busy = 1;
                end
                if (mon_busy) begin
                    off = ecnt - s;
                    k   = off / DIV;
                    if (k == 0)      eb = 1'b0;
                    else if (k == 9) eb = 1'b1;
                    else             eb = cur.b[k-1];
                    if (txd !== eb) bad++;
                    if (k >= 1 && k <= 8 && (off % DIV) == DIV / 2) dec[k-1] = txd;
                    if (off == FRAME - 1) begin
                        chk("frame_byte", int'(dec), int'(cur.b));
                        chk("frame_shape_errors", bad, 0);
                        mon_busy = 0;
                    end
                end
            end
        end
    end

    initial begin : stimulus
        int guard;
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        model_reset();
        #1 rst = 1'b0;
        #0.5;
        chk("reset_txd", int'(txd), 1);
        chk("reset_tx_idle", int'(tx_idle), 1);
        chk("reset_tx_full", int'(tx_full), 0);
        chk("reset_overflow", int'(overflow), 0);

        // Quiet line with no writes.
        idle(200);

        // Single byte.
        tick(1'b1, 8'hA5);
        idle(200);

        // Burst of six: fifth fits after the first pop, sixth overflows.
        for (int i = 1; i <= 6; i++) tick(1'b1, 8'(i));
        idle(5 * FRAME + 40);

        // Write landing just in time to chain after the last stop bit.
        tick(1'b1, 8'h55);
        idle(FRAME - 1);
        tick(1'b1, 8'h0F);
        idle(2 * FRAME + 20);

        // All-zero then all-one bytes back to back.
        tick(1'b1, 8'h00);
        tick(1'b1, 8'hFF);
        idle(2 * FRAME + 20);

        // Reset in the middle of a frame with two bytes still queued.
        tick(1'b1, 8'hFF);
        tick(1'b1, 8'h11);
        tick(1'b1, 8'h22);
        idle(60);
        @(posedge clk);
        #0.5 rst = 1'b1;
        #0.2;
        chk("midframe_rst_txd", int'(txd), 1);
        chk("midframe_rst_tx_idle", int'(tx_idle), 1);
        chk("midframe_rst_tx_full", int'(tx_full), 0);
        chk("midframe_rst_overflow", int'(overflow), 0);
        model_reset();
        @(posedge clk);
        #0.5 rst = 1'b0;
        idle(200);

        // Randomized traffic, sparse singles mixed with short bursts.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                for (int j = 0; j < int'($urandom_range(2, 7)); j++)
                    tick(1'b1, 8'($urandom));
            end else begin
                tick($urandom_range(0, 99) < 3, 8'($urandom));
            end
        end

        // Drain everything scheduled, bounded.
        guard = 0;
        while (ecnt < sched_end + 2 && guard < 4 * DEPTH * FRAME) begin
            tick(1'b0, 8'h00);
            guard++;
        end
        if (ecnt < sched_end + 2) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: edge %0d required at least %0d", ecnt, sched_end + 2);
        end
        idle(4);
        chk("frames_outstanding", expq.size(), 0);
        chk("monitor_idle_at_end", int'(mon_busy), 0);
        chk("final_txd", int'(txd), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
